regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param_if.sv | 27 ++
 rtl/regfile_param.sv | 82 ++++++++
 tb/tb_regfile_param.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_param_if.sv
// Register-file bus: two asynchronous read ports, one write port, and the clear-sweep handshake.
// The master drives addresses, write data and requests. The slave returns read data and sweep status.
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ReadAddr1;
  logic [ADDR_W-1:0] ReadAddr2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [ADDR_W-1:0] WriteAddr;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite;
  logic              Clear;
  logic              Busy;
  logic              ClearDone;

  modport master (
    output ReadAddr1, ReadAddr2, WriteAddr, WriteData, RegWrite, Clear,
    input  ReadData1, ReadData2, Busy, ClearDone
  );

  modport slave (
    input  ReadAddr1, ReadAddr2, WriteAddr, WriteData, RegWrite, Clear,
    output ReadData1, ReadData2, Busy, ClearDone
  );
endinterface

// File: rtl/regfile_param.sv
// Parameterised 2R1W register file with optional hardwired zero register and write-to-read bypass.
// A Clear request starts a one-register-per-cycle sweep that zeroes the whole array.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic             Clock,
  input logic             Reset_n,
  regfile_param_if.slave  bus
);
  localparam int                NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NREGS - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              done_q;
  logic [DATA_W-1:0] regs_q [NREGS];

  logic              wr_en;
  logic              bypass_en;
  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];

  assign wr_en     = (state_q == IDLE) && bus.RegWrite &&
                     !((ZERO_REG != 0) && (bus.WriteAddr == '0));
  assign bypass_en = (BYPASS != 0) && (state_q == IDLE) && bus.RegWrite;

  assign raddr[0] = bus.ReadAddr1;
  assign raddr[1] = bus.ReadAddr2;

  // NOTE: every variable assigned in always_comb receives a value on every path, so no latch is inferred.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = regs_q[raddr[p]];
      if (bypass_en && (bus.WriteAddr == raddr[p])) rdata[p] = bus.WriteData;
      // The zero register wins over bypass, so a dropped write never appears on a read port.
      if ((ZERO_REG != 0) && (raddr[p] == '0)) rdata[p] = '0;
    end
  end

  assign bus.ReadData1 = rdata[0];
  assign bus.ReadData2 = rdata[1];
  assign bus.Busy      = (state_q == SWEEP);
  assign bus.ClearDone = done_q;

  // NOTE: the storage array is reset here on purpose. Reset must zero every register immediately,
  // so the array cannot be mapped onto a RAM macro.
  // NOTE: all state in this block uses non-blocking assignments, so every update sees pre-edge values.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // The write on the edge that accepts Clear still lands. The sweep overwrites it later.
          if (wr_en) regs_q[bus.WriteAddr] <= bus.WriteData;
          if (bus.Clear) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
          end
        end
        SWEEP: begin
          regs_q[cnt_q] <= '0;
          cnt_q         <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_param.sv
// Randomised self-checking bench for regfile_param. The bypass and non-bypass instances are driven
// in lockstep and compared against one array-based model.
module tb_regfile_param;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic Clock;
  logic Reset_n;

  regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) ifc ();
  regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) ifc_nb ();

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .bus(ifc.slave)
  );
  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .Clock(Clock), .Reset_n(Reset_n), .bus(ifc_nb.slave)
  );

  assign ifc_nb.ReadAddr1 = ifc.ReadAddr1;
  assign ifc_nb.ReadAddr2 = ifc.ReadAddr2;
  assign ifc_nb.WriteAddr = ifc.WriteAddr;
  assign ifc_nb.WriteData = ifc.WriteData;
  assign ifc_nb.RegWrite  = ifc.RegWrite;
  assign ifc_nb.Clear     = ifc.Clear;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model: plain register array plus a count of the sweep steps already done.
  logic [DW-1:0] mem [NR];
  bit            m_sweeping;
  int            m_steps;
  bit            m_done;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) mem[i] = '0;
    m_sweeping = 0;
    m_steps    = 0;
    m_done     = 0;
  endfunction

  function automatic void model_edge();
    m_done = 0;
    if (!Reset_n) begin
      model_reset();
    end else if (m_sweeping) begin
      mem[m_steps] = '0;
      m_steps++;
      if (m_steps == NR) begin
        m_sweeping = 0;
        m_steps    = 0;
        m_done     = 1;
      end
    end else begin
      if (ifc.RegWrite && ifc.WriteAddr != 0) mem[ifc.WriteAddr] = ifc.WriteData;
      if (ifc.Clear) begin
        m_sweeping = 1;
        m_steps    = 0;
      end
    end
  endfunction

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && !m_sweeping && ifc.RegWrite && ifc.WriteAddr == a) return ifc.WriteData;
    return mem[a];
  endfunction

  task automatic tick();
    @(posedge Clock);
    model_edge();
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rd1"},     ifc.ReadData1,       exp_read(ifc.ReadAddr1, 1));
    check({tag, ".rd2"},     ifc.ReadData2,       exp_read(ifc.ReadAddr2, 1));
    check({tag, ".nb_rd1"},  ifc_nb.ReadData1,    exp_read(ifc.ReadAddr1, 0));
    check({tag, ".nb_rd2"},  ifc_nb.ReadData2,    exp_read(ifc.ReadAddr2, 0));
    check({tag, ".busy"},    32'(ifc.Busy),       32'(m_sweeping));
    check({tag, ".done"},    32'(ifc.ClearDone),  32'(m_done));
    check({tag, ".nb_busy"}, 32'(ifc_nb.Busy),    32'(m_sweeping));
  endtask

  task automatic drive(input bit we, input int wa, input logic [DW-1:0] wd, input bit clr,
                       input int ra1, input int ra2);
    ifc.RegWrite  = we;
    ifc.WriteAddr = AW'(wa);
    ifc.WriteData = wd;
    ifc.Clear     = clr;
    ifc.ReadAddr1 = AW'(ra1);
    ifc.ReadAddr2 = AW'(ra2);
  endtask

  task automatic fill_index_plus_one();
    for (int a = 0; a < NR; a++) begin
      drive(1, a, DW'(a + 1), 0, a, NR - 1 - a);
      settle();
      check_outputs("fill");
      tick();
    end
    drive(0, 0, '0, 0, 0, 0);
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;

    Reset_n = 1'b0;
    drive(0, 0, '0, 0, 5, 6);
    model_reset();
    #3;
    check_outputs("reset");
    check("reset.busy_k", 32'(ifc.Busy), 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;

    // First write right after reset release, then read back on both ports.
    drive(1, 5, 32'hDEADBEEF, 0, 1, 6);
    settle();
    tick();
    drive(0, 0, '0, 0, 5, 6);
    settle();
    check("wr5.rd1", ifc.ReadData1, 32'hDEADBEEF);
    check("wr6.rd2", ifc.ReadData2, 32'h0);
    check_outputs("wr5");

    // Writes to register 0 are dropped, with or without bypass.
    drive(1, 0, 32'h12345678, 0, 0, 0);
    settle();
    check("zero.pre.rd1", ifc.ReadData1, 32'h0);
    check("zero.pre.rd2", ifc.ReadData2, 32'h0);
    check_outputs("zero.pre");
    tick();
    drive(0, 0, '0, 0, 0, 0);
    settle();
    check("zero.post.rd1", ifc.ReadData1, 32'h0);
    check("zero.post.rd2", ifc_nb.ReadData2, 32'h0);

    // Same-cycle bypass on one instance, stored value only on the other.
    drive(1, 7, 32'hA5A5A5A5, 0, 3, 7);
    settle();
    check("byp.rd2", ifc.ReadData2, 32'hA5A5A5A5);
    check("nobyp.pre.rd2", ifc_nb.ReadData2, 32'h0);
    check_outputs("byp");
    tick();
    drive(0, 0, '0, 0, 3, 7);
    settle();
    check("nobyp.post.rd2", ifc_nb.ReadData2, 32'hA5A5A5A5);
    check_outputs("byp.post");

    // Random traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(1, 0) == 1, $urandom_range(NR - 1, 0), $urandom,
            $urandom_range(79, 0) == 0, $urandom_range(NR - 1, 0), $urandom_range(NR - 1, 0));
      if ($urandom_range(3, 0) == 0) ifc.ReadAddr1 = ifc.WriteAddr;
      settle();
      check_outputs("rand");
      tick();
    end
    drive(0, 0, '0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      settle();
      check_outputs("drain");
      tick();
    end

    // Full sweep. Clear is held through the finishing edge and writes are attempted throughout.
    fill_index_plus_one();
    drive(0, 0, '0, 1, 4, 9);
    settle();
    tick();
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (ifc.Busy) busy_cnt++;
      if (ifc.ClearDone) done_cnt++;
      drive(i <= 31, $urandom_range(NR - 1, 1), $urandom, i <= 31,
            $urandom_range(NR - 1, 0), $urandom_range(NR - 1, 0));
      settle();
      check_outputs("sweep");
      tick();
    end
    check("sweep.busy_cycles", 32'(busy_cnt), 32'd32);
    check("sweep.done_pulses", 32'(done_cnt), 32'd1);
    for (int a = 0; a < NR; a++) begin
      drive(0, 0, '0, 0, a, NR - 1 - a);
      settle();
      check("swept.rd1", ifc.ReadData1, 32'h0);
      check_outputs("swept");
      tick();
    end

    // Reset asserted in the middle of a sweep.
    fill_index_plus_one();
    drive(0, 0, '0, 1, 8, 20);
    settle();
    tick();
    ifc.Clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      check_outputs("abort.pre");
      tick();
    end
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    check("abort.busy", 32'(ifc.Busy), 32'd0);
    check("abort.done", 32'(ifc.ClearDone), 32'd0);
    for (int a = 0; a < NR; a += 2) begin
      ifc.ReadAddr1 = AW'(a);
      ifc.ReadAddr2 = AW'(a + 1);
      #1;
      check("abort.rd1", ifc.ReadData1, 32'h0);
      check("abort.rd2", ifc.ReadData2, 32'h0);
    end
    @(negedge Clock);
    Reset_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (ifc.ClearDone) done_cnt++;
      drive(0, 0, '0, 0, $urandom_range(NR - 1, 0), $urandom_range(NR - 1, 0));
      settle();
      check_outputs("abort.post");
      tick();
    end
    check("abort.no_done", 32'(done_cnt), 32'd0);

    // Clear and a write to register 3 on the same idle edge.
    fill_index_plus_one();
    drive(1, 3, 32'h55, 1, 3, 3);
    settle();
    tick();
    drive(0, 0, '0, 0, 3, 3);
    settle();
    check("cw.rd3_new", ifc.ReadData1, 32'h55);
    check_outputs("cw");
    for (int i = 0; i < 4; i++) tick();
    settle();
    check("cw.rd3_cleared", ifc.ReadData1, 32'h0);
    for (int i = 0; i < 30; i++) begin
      settle();
      check_outputs("cw.tail");
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
